// File: rtl/fft_frame_loader.sv
// fft_frame_loader: packs a serial valid/ready sample stream into 4-sample frames for the 4-point FFT core.
// Build option FFT_LOADER_BIT_REVERSE_EN loads frames in bit-reversed order for a decimation-in-time core.
`timescale 1ns/1ps
module fft_frame_loader #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_first,
   output logic              in_ready,
   output logic [DATA_W-1:0] x_0,
   output logic [DATA_W-1:0] x_1,
   output logic [DATA_W-1:0] x_2,
   output logic [DATA_W-1:0] x_3,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              sync_err
);

   typedef enum logic {FILL, PEND} state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] fill_buf [4];
   logic [1:0]        wr_cnt, wr_cnt_next;
   logic [1:0]        buf_idx;
   logic              buf_we;
   logic              load_direct, load_pend;
   logic              resync_err;
   logic              deliver;
   logic [DATA_W-1:0] s0, s1, s2, s3;

   assign deliver = frame_valid && frame_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_next  = state;
      wr_cnt_next = wr_cnt;
      in_ready    = 1'b0;
      buf_we      = 1'b0;
      buf_idx     = wr_cnt;
      load_direct = 1'b0;
      load_pend   = 1'b0;
      resync_err  = 1'b0;
      unique case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_first) begin
                  buf_we      = 1'b1;
                  buf_idx     = 2'd0;
                  wr_cnt_next = 2'd1;
                  resync_err  = (wr_cnt != 2'd0);
               end else if (wr_cnt == 2'd3) begin
                  // Output slot free or emptying this edge: bypass buf3 and load straight away.
                  if (!frame_valid || deliver) begin
                     load_direct = 1'b1;
                     wr_cnt_next = 2'd0;
                  end else begin
                     buf_we     = 1'b1;
                     state_next = PEND;
                  end
               end else begin
                  buf_we      = 1'b1;
                  wr_cnt_next = wr_cnt + 2'd1;
               end
            end
         end
         PEND: begin
            if (deliver) begin
               load_pend   = 1'b1;
               wr_cnt_next = 2'd0;
               state_next  = FILL;
            end
         end
      endcase
   end

   assign s0 = fill_buf[0];
   assign s1 = fill_buf[1];
   assign s2 = fill_buf[2];
   assign s3 = load_direct ? in_data : fill_buf[3];

   // NOTE: the fill buffer is cleared on reset too, so no stale partial frame survives it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) fill_buf[i] <= '0;
         wr_cnt      <= 2'd0;
         x_0         <= '0;
         x_1         <= '0;
         x_2         <= '0;
         x_3         <= '0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         sync_err    <= 1'b0;
      end else begin
         wr_cnt   <= wr_cnt_next;
         sync_err <= resync_err;
         if (buf_we) fill_buf[buf_idx] <= in_data;
         if (load_direct || load_pend) begin
`ifdef FFT_LOADER_BIT_REVERSE_EN
            x_0 <= s0;
            x_1 <= s2;
            x_2 <= s1;
            x_3 <= s3;
`else
            x_0 <= s0;
            x_1 <= s1;
            x_2 <= s2;
            x_3 <= s3;
`endif
            frame_valid <= 1'b1;
         end else if (deliver) begin
            frame_valid <= 1'b0;
         end
         if (deliver) frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

endmodule
